// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rf_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int AW       = $clog2(NUM_REGS);

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } rf_wr_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } wb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two requester handshakes plus the regfile write port.
interface regfile_wb_arbiter_if;

  logic                   req0_valid;
  logic [rf_pkg::AW-1:0]  req0_addr;
  logic [rf_pkg::XLEN-1:0] req0_data;
  logic                   req0_ready;
  logic                   req1_valid;
  logic [rf_pkg::AW-1:0]  req1_addr;
  logic [rf_pkg::XLEN-1:0] req1_data;
  logic                   req1_ready;
  logic                   rf_we;
  logic [rf_pkg::AW-1:0]  rf_waddr;
  logic [rf_pkg::XLEN-1:0] rf_wdata;
  logic                   init_done;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output rf_we, rf_waddr, rf_wdata, init_done
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  rf_we, rf_waddr, rf_wdata, init_done
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves on contended grants.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  logic r_ptr;

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      case (i_valid)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
        default: o_grant = 2'b00;
      endcase
    end
  end

  // After a contended grant the other requester is favoured next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_en && (&i_valid)) begin
      r_ptr <= ~r_ptr;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port owner: init sweep of x1..xN-1, then round-robin writeback.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter logic [XLEN-1:0] INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  wb_state_e     r_state;
  logic [AW-1:0] r_cnt;
  rf_wr_t        r_out;
  logic          r_init_done;
  logic          w_run;
  logic [1:0]    w_valid;
  logic [1:0]    w_grant;

  assign w_run   = (r_state == ST_RUN);
  assign w_valid = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_run),
    .i_valid (w_valid),
    .o_grant (w_grant)
  );

  assign bus.req0_ready = w_grant[0];
  assign bus.req1_ready = w_grant[1];
  assign bus.rf_we      = r_out.we;
  assign bus.rf_waddr   = r_out.addr;
  assign bus.rf_wdata   = r_out.data;
  assign bus.init_done  = r_init_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= AW'(1);
      r_out       <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_out.we   <= 1'b1;
          r_out.addr <= r_cnt;
          r_out.data <= INIT_VAL;
          if (r_cnt == AW'(NUM_REGS - 1)) begin
            r_state <= ST_RUN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          r_init_done <= 1'b1;
          // A granted write to x0 still handshakes but never reaches the regfile.
          if (w_grant[0]) begin
            r_out.we   <= (bus.req0_addr != '0);
            r_out.addr <= bus.req0_addr;
            r_out.data <= bus.req0_data;
          end else if (w_grant[1]) begin
            r_out.we   <= (bus.req1_addr != '0);
            r_out.addr <= bus.req1_addr;
            r_out.data <= bus.req1_data;
          end else begin
            r_out <= '0;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter against a cycle-count reference model.
module tb_regfile_wb_arbiter;

  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.INIT_VAL(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: k = rising edges seen since reset release.
  int          k;
  bit          fav;
  bit          pend0, pend1;
  bit          exp_we, dec_we;
  logic [4:0]  exp_addr, dec_addr;
  logic [31:0] exp_data, dec_data;

  bit          c_v0, c_v1;
  logic [4:0]  c_a0, c_a1;
  logic [31:0] c_d0, c_d1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_bus();
    bus.req0_valid = c_v0;
    bus.req0_addr  = c_a0;
    bus.req0_data  = c_d0;
    bus.req1_valid = c_v1;
    bus.req1_addr  = c_a1;
    bus.req1_data  = c_d1;
  endtask

  task automatic step(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1);
    bit g0;
    bit g1;
    @(negedge clk);
    check("rf_we", {31'b0, bus.rf_we}, {31'b0, exp_we});
    if (exp_we) begin
      check("rf_waddr", {27'b0, bus.rf_waddr}, {27'b0, exp_addr});
      check("rf_wdata", bus.rf_wdata, exp_data);
    end
    check("init_done", {31'b0, bus.init_done}, {31'b0, (k >= NREG)});
    // A requester still waiting for ready keeps its request unchanged.
    if (!pend0) begin c_v0 = v0; c_a0 = a0; c_d0 = d0; end
    if (!pend1) begin c_v1 = v1; c_a1 = a1; c_d1 = d1; end
    drive_bus();
    #1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (k >= NREG - 1) begin
      if (c_v0 && c_v1) begin
        if (!fav) g0 = 1'b1; else g1 = 1'b1;
        fav = ~fav;
      end else begin
        g0 = c_v0;
        g1 = c_v1;
      end
    end
    check("req0_ready", {31'b0, bus.req0_ready}, {31'b0, g0});
    check("req1_ready", {31'b0, bus.req1_ready}, {31'b0, g1});
    if (g0) $display("t=%0t grant req0 addr=%0d data=%h", $time, c_a0, c_d0);
    if (g1) $display("t=%0t grant req1 addr=%0d data=%h", $time, c_a1, c_d1);
    pend0 = c_v0 && !g0;
    pend1 = c_v1 && !g1;
    dec_we = 1'b0; dec_addr = '0; dec_data = '0;
    if (g0) begin dec_we = (c_a0 != 0); dec_addr = c_a0; dec_data = c_d0; end
    if (g1) begin dec_we = (c_a1 != 0); dec_addr = c_a1; dec_data = c_d1; end
    @(posedge clk);
    k++;
    if (k <= NREG - 1) begin
      exp_we = 1'b1; exp_addr = 5'(k); exp_data = 32'h0;
    end else begin
      exp_we = dec_we; exp_addr = dec_addr; exp_data = dec_data;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    c_v0 = 0; c_v1 = 0; c_a0 = 0; c_a1 = 0; c_d0 = 0; c_d1 = 0;
    drive_bus();
    pend0 = 0; pend1 = 0; fav = 0; k = 0;
    exp_we = 0; exp_addr = 0; exp_data = 0;
    @(negedge clk);
    check("rst_we", {31'b0, bus.rf_we}, 32'h0);
    check("rst_waddr", {27'b0, bus.rf_waddr}, 32'h0);
    check("rst_wdata", bus.rf_wdata, 32'h0);
    check("rst_init_done", {31'b0, bus.init_done}, 32'h0);
    check("rst_ready", {30'b0, bus.req1_ready, bus.req0_ready}, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    // Reset then idle through the sweep.
    do_reset();
    idle(40);

    // Request held through INIT, granted on the first RUN cycle.
    do_reset();
    for (int i = 0; i < 34; i++) step(1, 5'd5, 32'hDEAD, 0, 0, 0);
    idle(2);

    // Continuous dual contention alternates grants.
    for (int i = 0; i < 6; i++) step(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
    idle(2);

    // Single-requester grants leave the pointer alone.
    step(0, 0, 0, 1, 5'd9, 32'h99);
    step(0, 0, 0, 1, 5'd10, 32'hAA);
    step(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
    step(0, 0, 0, 0, 0, 0);
    idle(2);

    // Write to x0 handshakes but drops the write.
    step(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end

    // Asynchronous reset between edges while a write is in flight.
    idle(2);
    step(1, 5'd7, 32'h77, 0, 0, 0);
    #2;
    check("pre_rst_we", {31'b0, bus.rf_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_we", {31'b0, bus.rf_we}, 32'h0);
    check("async_rst_init_done", {31'b0, bus.init_done}, 32'h0);
    do_reset();
    idle(35);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
